ikaopll_lfo_param: RTL and testbench

- Parametrised second-generation LFO for the IKAOPLL core.
- Produces the vibrato phase-modulation step (o_PMVAL) and the tremolo amplitude-modulation value (o_AMVAL).
- Prescaler, PM divider and AM triangle counter widths are generics.
- Adds selectable AM/PM depth and an explicit up/down triangle FSM. Sits beside the phase generator (PM) and the envelope generator (AM).

---
 rtl/ikaopll_lfo_param_if.sv | 25 ++
 rtl/ikaopll_lfo_param.sv | 140 ++++++++++++++
 tb/tb_ikaopll_lfo_param.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ikaopll_lfo_param_if.sv
// LFO control/result bundle: frame strobe, test bits, depth selects and LFO outputs.
interface ikaopll_lfo_param_if #(
    parameter int unsigned PM_W     = 3,
    parameter int unsigned AM_OUT_W = 4
);
    logic                i_FRAME_TICK;
    logic [3:0]          i_TEST;
    logic                i_AM_DEPTH;
    logic                i_PM_DEPTH;
    logic [PM_W-1:0]     o_PMVAL;
    logic [AM_OUT_W-1:0] o_AMVAL;
    logic                o_AM_DIR;

    // Driver side (sequencer / testbench)
    modport master (
        output i_FRAME_TICK, i_TEST, i_AM_DEPTH, i_PM_DEPTH,
        input  o_PMVAL, o_AMVAL, o_AM_DIR
    );

    // LFO side
    modport slave (
        input  i_FRAME_TICK, i_TEST, i_AM_DEPTH, i_PM_DEPTH,
        output o_PMVAL, o_AMVAL, o_AM_DIR
    );
endinterface

// File: rtl/ikaopll_lfo_param.sv
// Parametrised IKAOPLL LFO: vibrato step counter (PM) and tremolo triangle (AM)
// with selectable depth. Optional macro IKAOPLL_LFO_SYNC_EN adds i_LFO_SYNC,
// a synchronous LFO restart equivalent to the TEST[1] clear.
module ikaopll_lfo_param #(
    parameter int unsigned PRESC_W  = 6,
    parameter int unsigned PMDIV_W  = 4,
    parameter int unsigned PM_W     = 3,
    parameter int unsigned AM_W     = 7,
    parameter int unsigned AM_PEAK  = 105,
    parameter int unsigned AM_SHIFT = 3,
    parameter int unsigned AM_OUT_W = 4
) (
    input  logic                  i_EMUCLK,
    input  logic                  i_IC_n,
    input  logic                  i_phi1_NCEN_n,
`ifdef IKAOPLL_LFO_SYNC_EN
    input  logic                  i_LFO_SYNC,
`endif
    ikaopll_lfo_param_if.slave    io_lfo
);
    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } dir_t;

    logic [PRESC_W-1:0]  r_presc;
    logic [PMDIV_W-1:0]  r_pm_div;
    logic [PM_W-1:0]     r_pm_cnt;
    logic [AM_W-1:0]     r_am_cnt;
    dir_t                r_dir;
    logic [AM_OUT_W-1:0] r_amval;
    logic [PM_W-1:0]     r_pmval;

    logic                w_en;
    logic                w_tick;
    logic                w_clr;
    logic                w_presc_co;
    logic                w_pm_step;
    logic                w_am_step;
    dir_t                w_dir_nxt;
    logic [AM_W-1:0]     w_am_nxt;
    logic [AM_W-1:0]     w_am_shr;
    logic [AM_W-1:0]     w_am_dep;
    logic                w_unused;

    assign w_en       = ~i_phi1_NCEN_n;
    assign w_tick     = io_lfo.i_FRAME_TICK & w_en;
`ifdef IKAOPLL_LFO_SYNC_EN
    assign w_clr      = w_en & (io_lfo.i_TEST[1] | i_LFO_SYNC);
`else
    assign w_clr      = w_en & io_lfo.i_TEST[1];
`endif
    assign w_presc_co = (&r_presc) & w_tick;
    // A fast-step tick coinciding with a carry still yields a single step (OR, not sum)
    assign w_pm_step  = ((&r_pm_div) & w_presc_co) | (w_tick & io_lfo.i_TEST[3]);
    assign w_am_step  = w_presc_co | (w_tick & io_lfo.i_TEST[3]);
    assign w_unused   = &{1'b0, io_lfo.i_TEST[0], io_lfo.i_TEST[2]};

    // Prescaler, PM divider and PM step counter
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_presc  <= '0;
            r_pm_div <= '0;
            r_pm_cnt <= '0;
        end else if (w_clr) begin
            r_presc  <= '0;
            r_pm_div <= '0;
            r_pm_cnt <= '0;
        end else begin
            if (w_tick)     r_presc  <= r_presc + PRESC_W'(1);
            if (w_presc_co) r_pm_div <= r_pm_div + PMDIV_W'(1);
            if (w_pm_step)  r_pm_cnt <= r_pm_cnt + PM_W'(1);
        end
    end

    // Triangle FSM state register (direction) and AM counter
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_dir    <= ST_UP;
            r_am_cnt <= '0;
        end else if (w_en) begin
            r_dir    <= w_dir_nxt;
            r_am_cnt <= w_am_nxt;
        end
    end

    // Triangle FSM next state: turn at the peak and at zero, each held one step
    always_comb begin
        w_dir_nxt = r_dir;
        w_am_nxt  = r_am_cnt;
        if (w_clr) begin
            w_dir_nxt = ST_UP;
            w_am_nxt  = '0;
        end else if (w_am_step) begin
            case (r_dir)
                ST_UP: begin
                    if (r_am_cnt == AM_W'(AM_PEAK)) begin
                        w_dir_nxt = ST_DOWN;
                        w_am_nxt  = AM_W'(AM_PEAK - 1);
                    end else begin
                        w_am_nxt  = r_am_cnt + AM_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (r_am_cnt == '0) begin
                        w_dir_nxt = ST_UP;
                        w_am_nxt  = AM_W'(1);
                    end else begin
                        w_am_nxt  = r_am_cnt - AM_W'(1);
                    end
                end
                default: begin
                    w_dir_nxt = ST_UP;
                    w_am_nxt  = '0;
                end
            endcase
        end
    end

    // AM output scaling: fixed shift, then an extra /4 at reduced depth
    always_comb begin
        w_am_shr = r_am_cnt >> AM_SHIFT;
        w_am_dep = io_lfo.i_AM_DEPTH ? w_am_shr : (w_am_shr >> 2);
    end

    // Output registers, one en cycle behind the counters
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_amval <= '0;
            r_pmval <= '0;
        end else if (w_en) begin
            r_amval <= AM_OUT_W'(w_am_dep);
            r_pmval <= io_lfo.i_PM_DEPTH ? r_pm_cnt : {1'b0, r_pm_cnt[PM_W-2:0]};
        end
    end

    assign io_lfo.o_AMVAL  = r_amval;
    assign io_lfo.o_PMVAL  = r_pmval;
    assign io_lfo.o_AM_DIR = r_dir;
endmodule

// File: tb/tb_ikaopll_lfo_param.sv
// Directed bench for ikaopll_lfo_param with hand-computed expectations.
module tb_ikaopll_lfo_param;
    logic clk;
    logic rst_n;
    logic ncen_n;
`ifdef IKAOPLL_LFO_SYNC_EN
    logic lfo_sync;
`endif
    int   checks;
    int   failures;

    ikaopll_lfo_param_if #(.PM_W(3), .AM_OUT_W(4)) lfo_if ();

    ikaopll_lfo_param dut (
        .i_EMUCLK      (clk),
        .i_IC_n        (rst_n),
        .i_phi1_NCEN_n (ncen_n),
`ifdef IKAOPLL_LFO_SYNC_EN
        .i_LFO_SYNC    (lfo_sync),
`endif
        .io_lfo        (lfo_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Advance n active edges and settle 1 time unit past the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic tick, input logic [3:0] test);
        lfo_if.i_FRAME_TICK = tick;
        lfo_if.i_TEST       = test;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ncen_n   = 1'b0;
`ifdef IKAOPLL_LFO_SYNC_EN
        lfo_sync = 1'b0;
`endif
        lfo_if.i_AM_DEPTH = 1'b1;
        lfo_if.i_PM_DEPTH = 1'b1;
        set_in(1'b0, 4'd0);

        #3;
        chk("rst_amval", 32'(lfo_if.o_AMVAL), 0);
        chk("rst_pmval", 32'(lfo_if.o_PMVAL), 0);
        chk("rst_dir",   32'(lfo_if.o_AM_DIR), 0);

        // Free run, tick every en cycle
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 4'd0);
        cyc(63);
        chk("run_am63", 32'(dut.r_am_cnt), 0);
        cyc(1);
        chk("run_am64", 32'(dut.r_am_cnt), 1);
        cyc(960);
        chk("run_pm1024_out", 32'(lfo_if.o_PMVAL), 0);
        chk("run_pm1024_cnt", 32'(dut.r_pm_cnt), 1);
        cyc(1);
        chk("run_pm1025_out", 32'(lfo_if.o_PMVAL), 1);
        cyc(7167);
        chk("run_pm8192_cnt", 32'(dut.r_pm_cnt), 0);
        chk("run_pm8192_out", 32'(lfo_if.o_PMVAL), 7);
        cyc(1);
        chk("run_pm8193_out", 32'(lfo_if.o_PMVAL), 0);
        chk("run_am8193",     32'(dut.r_am_cnt), 82);
        chk("run_dir8193",    32'(lfo_if.o_AM_DIR), 1);

        // TEST[1] clear, outputs follow one en cycle later
        set_in(1'b1, 4'b0010);
        cyc(1);
        chk("clr_am",      32'(dut.r_am_cnt), 0);
        chk("clr_presc",   32'(dut.r_presc), 0);
        chk("clr_dir",     32'(lfo_if.o_AM_DIR), 0);
        chk("clr_amval_d", 32'(lfo_if.o_AMVAL), 10);
        set_in(1'b0, 4'd0);
        cyc(1);
        chk("clr_amval", 32'(lfo_if.o_AMVAL), 0);
        set_in(1'b1, 4'b0010);
        cyc(5);
        chk("clr_hold_am",    32'(dut.r_am_cnt), 0);
        chk("clr_hold_presc", 32'(dut.r_presc), 0);

        // Fast step through one full triangle
        set_in(1'b1, 4'b1000);
        cyc(64);
        chk("fast_co_single", 32'(dut.r_am_cnt), 64);
        cyc(41);
        chk("fast_am105",    32'(dut.r_am_cnt), 105);
        chk("fast_dir105",   32'(lfo_if.o_AM_DIR), 0);
        chk("fast_amval105", 32'(lfo_if.o_AMVAL), 13);
        chk("fast_pm105",    32'(dut.r_pm_cnt), 1);
        cyc(1);
        chk("fast_am106",    32'(dut.r_am_cnt), 104);
        chk("fast_dir106",   32'(lfo_if.o_AM_DIR), 1);
        chk("fast_amval106", 32'(lfo_if.o_AMVAL), 13);
        chk("fast_pmval106", 32'(lfo_if.o_PMVAL), 1);
        cyc(104);
        chk("fast_am210",  32'(dut.r_am_cnt), 0);
        chk("fast_dir210", 32'(lfo_if.o_AM_DIR), 1);
        cyc(1);
        chk("fast_am211",  32'(dut.r_am_cnt), 1);
        chk("fast_dir211", 32'(lfo_if.o_AM_DIR), 0);

        // Reduced AM depth at the peak
        set_in(1'b1, 4'b0010);
        cyc(1);
        set_in(1'b1, 4'b1000);
        cyc(105);
        set_in(1'b0, 4'd0);
        lfo_if.i_AM_DEPTH = 1'b0;
        cyc(1);
        chk("amdep_red", 32'(lfo_if.o_AMVAL), 3);
        chk("amdep_cnt", 32'(dut.r_am_cnt), 105);
        lfo_if.i_AM_DEPTH = 1'b1;
        cyc(1);
        chk("amdep_full", 32'(lfo_if.o_AMVAL), 13);

        // Reduced PM depth with pm_cnt=6
        set_in(1'b1, 4'b0010);
        cyc(1);
        set_in(1'b1, 4'b1000);
        cyc(6);
        chk("pmdep_cnt", 32'(dut.r_pm_cnt), 6);
        set_in(1'b0, 4'd0);
        lfo_if.i_PM_DEPTH = 1'b0;
        cyc(1);
        chk("pmdep_red", 32'(lfo_if.o_PMVAL), 2);
        lfo_if.i_PM_DEPTH = 1'b1;
        cyc(1);
        chk("pmdep_full", 32'(lfo_if.o_PMVAL), 6);

        // Single-cycle clear pulse with live counters
        set_in(1'b1, 4'b0010);
        cyc(1);
        set_in(1'b1, 4'b1000);
        cyc(77);
        chk("pulse_pre_am", 32'(dut.r_am_cnt), 77);
        chk("pulse_pre_pm", 32'(dut.r_pm_cnt), 5);
        set_in(1'b1, 4'b0010);
        cyc(1);
        chk("pulse_am",      32'(dut.r_am_cnt), 0);
        chk("pulse_pm",      32'(dut.r_pm_cnt), 0);
        chk("pulse_amval_d", 32'(lfo_if.o_AMVAL), 9);
        chk("pulse_pmval_d", 32'(lfo_if.o_PMVAL), 5);
        set_in(1'b0, 4'd0);
        cyc(1);
        chk("pulse_amval", 32'(lfo_if.o_AMVAL), 0);
        chk("pulse_pmval", 32'(lfo_if.o_PMVAL), 0);

        // Clear wins over fast step
        set_in(1'b1, 4'b1000);
        cyc(3);
        chk("both_pre", 32'(dut.r_am_cnt), 3);
        set_in(1'b1, 4'b1010);
        cyc(1);
        chk("both_am", 32'(dut.r_am_cnt), 0);
        chk("both_pm", 32'(dut.r_pm_cnt), 0);

        // Enable held off: nothing moves
        set_in(1'b1, 4'b1000);
        cyc(50);
        ncen_n = 1'b1;
        cyc(100);
        chk("ncen_am",    32'(dut.r_am_cnt), 50);
        chk("ncen_pm",    32'(dut.r_pm_cnt), 2);
        chk("ncen_presc", 32'(dut.r_presc), 50);
        chk("ncen_amval", 32'(lfo_if.o_AMVAL), 6);
        chk("ncen_pmval", 32'(lfo_if.o_PMVAL), 1);
        ncen_n = 1'b0;

`ifdef IKAOPLL_LFO_SYNC_EN
        // LFO sync restart
        set_in(1'b1, 4'b0010);
        cyc(1);
        set_in(1'b1, 4'b1000);
        cyc(30);
        chk("sync_pre", 32'(dut.r_am_cnt), 30);
        lfo_sync = 1'b1;
        cyc(1);
        chk("sync_am",  32'(dut.r_am_cnt), 0);
        chk("sync_dir", 32'(lfo_if.o_AM_DIR), 0);
        lfo_sync = 1'b0;
`endif

        // Asynchronous reset mid-run while falling
        set_in(1'b1, 4'b0010);
        cyc(1);
        set_in(1'b1, 4'b1000);
        cyc(160);
        chk("arst_pre_am",  32'(dut.r_am_cnt), 50);
        chk("arst_pre_dir", 32'(lfo_if.o_AM_DIR), 1);
        cyc(1);
        chk("arst_pre_amval", 32'(lfo_if.o_AMVAL), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_amval", 32'(lfo_if.o_AMVAL), 0);
        chk("arst_pmval", 32'(lfo_if.o_PMVAL), 0);
        chk("arst_dir",   32'(lfo_if.o_AM_DIR), 0);
        chk("arst_am",    32'(dut.r_am_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
